// File: rtl/dispatcher_pkg.sv
// Shared types and constants for the dispatcher. Build option DSP_CDB_BYPASS_EN
// resolves operands straight from the CDB instead of stalling for one cycle.
package dispatcher_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned OPENUM_W = 6;
    localparam int unsigned TAG_W    = 5;
    localparam int unsigned REG_W    = 5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [TAG_W-1:0] ZERO_TAG = TAG_W'(0);
    localparam logic [REG_W-1:0] ZERO_REG = REG_W'(0);

`ifdef DSP_CDB_BYPASS_EN
    localparam logic BYPASS_BUILT = TRUE;
`else
    localparam logic BYPASS_BUILT = FALSE;
`endif

    typedef enum logic [OPENUM_W-1:0] {
        OP_NOP  = OPENUM_W'(0),
        OP_ADD  = OPENUM_W'(1),
        OP_SUB  = OPENUM_W'(2),
        OP_ADDI = OPENUM_W'(3),
        OP_LW   = OPENUM_W'(4),
        OP_SW   = OPENUM_W'(5),
        OP_BEQ  = OPENUM_W'(6)
    } openum_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Registered payload presented to the back end with the enable pulses
    typedef struct packed {
        logic [OPENUM_W-1:0] openum;
        logic [DATA_W-1:0]   v1;
        logic [DATA_W-1:0]   v2;
        logic [TAG_W-1:0]    q1;
        logic [TAG_W-1:0]    q2;
        logic [DATA_W-1:0]   imm;
        logic [ADDR_W-1:0]   pc;
        logic [TAG_W-1:0]    rob_id;
        logic [REG_W-1:0]    rename_rd;
        logic [TAG_W-1:0]    rename_tag;
    } dispatch_pkt_t;

    typedef struct packed {
        logic rs_ena;
        logic lsb_ena;
        logic rob_ena;
        logic rename_ena;
    } dispatch_ena_t;

endpackage

// File: rtl/dispatcher_if.sv
// Decoder/back-end bundle around the dispatcher; slave is the dispatcher side.
interface dispatcher_if;
    import dispatcher_pkg::*;

    logic                inst_valid;
    logic                inst_ready;
    logic [OPENUM_W-1:0] openum_in;
    logic                is_ls_in;
    logic [REG_W-1:0]    rd_in;
    logic [REG_W-1:0]    rs1_in;
    logic [REG_W-1:0]    rs2_in;
    logic [DATA_W-1:0]   imm_in;
    logic [ADDR_W-1:0]   pc_in;
    logic [DATA_W-1:0]   rf_V1;
    logic [DATA_W-1:0]   rf_V2;
    logic [TAG_W-1:0]    rf_Q1;
    logic [TAG_W-1:0]    rf_Q2;
    logic [TAG_W-1:0]    rob_free_tag;
    logic                rob_full;
    logic                rs_full;
    logic                lsb_full;
    logic                rob_ready1;
    logic                rob_ready2;
    logic [DATA_W-1:0]   rob_val1;
    logic [DATA_W-1:0]   rob_val2;
    logic                cdb_valid;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DATA_W-1:0]   cdb_result;
    logic                rollback;

    logic                rs_ena;
    logic                lsb_ena;
    logic [OPENUM_W-1:0] openum_out;
    logic [DATA_W-1:0]   V1_out;
    logic [DATA_W-1:0]   V2_out;
    logic [TAG_W-1:0]    Q1_out;
    logic [TAG_W-1:0]    Q2_out;
    logic [DATA_W-1:0]   imm_out;
    logic [ADDR_W-1:0]   pc_out;
    logic [TAG_W-1:0]    rob_id_out;
    logic                rob_ena;
    logic                rename_ena;
    logic [REG_W-1:0]    rename_rd;
    logic [TAG_W-1:0]    rename_tag;

    modport master (
        output inst_valid, openum_in, is_ls_in, rd_in, rs1_in, rs2_in, imm_in, pc_in,
               rf_V1, rf_V2, rf_Q1, rf_Q2, rob_free_tag, rob_full, rs_full, lsb_full,
               rob_ready1, rob_ready2, rob_val1, rob_val2, cdb_valid, cdb_tag,
               cdb_result, rollback,
        input  inst_ready, rs_ena, lsb_ena, openum_out, V1_out, V2_out, Q1_out, Q2_out,
               imm_out, pc_out, rob_id_out, rob_ena, rename_ena, rename_rd, rename_tag
    );

    modport slave (
        input  inst_valid, openum_in, is_ls_in, rd_in, rs1_in, rs2_in, imm_in, pc_in,
               rf_V1, rf_V2, rf_Q1, rf_Q2, rob_free_tag, rob_full, rs_full, lsb_full,
               rob_ready1, rob_ready2, rob_val1, rob_val2, cdb_valid, cdb_tag,
               cdb_result, rollback,
        output inst_ready, rs_ena, lsb_ena, openum_out, V1_out, V2_out, Q1_out, Q2_out,
               imm_out, pc_out, rob_id_out, rob_ena, rename_ena, rename_rd, rename_tag
    );

endinterface

// File: rtl/dispatcher_operand_resolve.sv
// Combinational resolution of one source operand to a value or a producer tag.
module dispatcher_operand_resolve
    import dispatcher_pkg::*;
(
    input  logic [REG_W-1:0]  rs,
    input  logic [DATA_W-1:0] rf_v,
    input  logic [TAG_W-1:0]  rf_q,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_result,
    input  logic              rob_ready,
    input  logic [DATA_W-1:0] rob_val,
    output logic [DATA_W-1:0] v_c,
    output logic [TAG_W-1:0]  q_c,
    output logic              cdb_hit_c
);

    // Producer is broadcasting this very cycle
    assign cdb_hit_c = cdb_valid && (rf_q != ZERO_TAG) && (cdb_tag == rf_q);

    always_comb begin
        v_c = DATA_W'(0);
        q_c = ZERO_TAG;
        if (rs == ZERO_REG) begin
            v_c = DATA_W'(0);
        end else if (rf_q == ZERO_TAG) begin
            v_c = rf_v;
        end else if (BYPASS_BUILT && cdb_hit_c) begin
            v_c = cdb_result;
        end else if (rob_ready) begin
            v_c = rob_val;
        end else begin
            q_c = rf_q;
        end
    end

endmodule

// File: rtl/dispatcher.sv
// Single-stage instruction dispatcher: operand resolve, ROB allocate, rename, issue.
// DSP_CDB_BYPASS_EN (see dispatcher_pkg) removes the one-cycle CDB collision stall.
module dispatcher
    import dispatcher_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    dispatcher_if.slave  bus
);

    state_e        state, state_nxt;
    dispatch_pkt_t pkt, pkt_nxt;
    dispatch_ena_t ena, ena_nxt;

    logic [DATA_W-1:0] v1_c, v2_c;
    logic [TAG_W-1:0]  q1_c, q2_c;
    logic              hit1_c, hit2_c;
    logic              bypass_stall;
    logic              struct_ok;
    logic              accept;

    dispatcher_operand_resolve u_res1 (
        .rs        (bus.rs1_in),
        .rf_v      (bus.rf_V1),
        .rf_q      (bus.rf_Q1),
        .cdb_valid (bus.cdb_valid),
        .cdb_tag   (bus.cdb_tag),
        .cdb_result(bus.cdb_result),
        .rob_ready (bus.rob_ready1),
        .rob_val   (bus.rob_val1),
        .v_c       (v1_c),
        .q_c       (q1_c),
        .cdb_hit_c (hit1_c)
    );

    dispatcher_operand_resolve u_res2 (
        .rs        (bus.rs2_in),
        .rf_v      (bus.rf_V2),
        .rf_q      (bus.rf_Q2),
        .cdb_valid (bus.cdb_valid),
        .cdb_tag   (bus.cdb_tag),
        .cdb_result(bus.cdb_result),
        .rob_ready (bus.rob_ready2),
        .rob_val   (bus.rob_val2),
        .v_c       (v2_c),
        .q_c       (q2_c),
        .cdb_hit_c (hit2_c)
    );

    // Without the bypass, hold the instruction until the result lands in the ROB
    assign bypass_stall   = !BYPASS_BUILT && (hit1_c || hit2_c);
    assign struct_ok      = !bus.rob_full && (bus.is_ls_in ? !bus.lsb_full : !bus.rs_full);
    assign bus.inst_ready = (state == ST_RUN) && !bus.rollback && struct_ok && !bypass_stall;
    assign accept         = bus.inst_valid && bus.inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            pkt   <= '0;
            ena   <= '0;
        end else begin
            state <= state_nxt;
            pkt   <= pkt_nxt;
            ena   <= ena_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pkt_nxt        = pkt;
        pkt_nxt.openum = OPENUM_W'(OP_NOP);
        ena_nxt        = '0;
        case (state)
            ST_RUN: begin
                if (bus.rollback) begin
                    state_nxt = ST_FLUSH;
                end else if (accept) begin
                    ena_nxt.rs_ena     = !bus.is_ls_in;
                    ena_nxt.lsb_ena    = bus.is_ls_in;
                    ena_nxt.rob_ena    = TRUE;
                    ena_nxt.rename_ena = (bus.rd_in != ZERO_REG);
                    pkt_nxt.openum     = bus.openum_in;
                    pkt_nxt.v1         = v1_c;
                    pkt_nxt.v2         = v2_c;
                    pkt_nxt.q1         = q1_c;
                    pkt_nxt.q2         = q2_c;
                    pkt_nxt.imm        = bus.imm_in;
                    pkt_nxt.pc         = bus.pc_in;
                    pkt_nxt.rob_id     = bus.rob_free_tag;
                    pkt_nxt.rename_rd  = bus.rd_in;
                    pkt_nxt.rename_tag = bus.rob_free_tag;
                end
            end
            ST_FLUSH: begin
                state_nxt = bus.rollback ? ST_FLUSH : ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign bus.rs_ena     = ena.rs_ena;
    assign bus.lsb_ena    = ena.lsb_ena;
    assign bus.rob_ena    = ena.rob_ena;
    assign bus.rename_ena = ena.rename_ena;
    assign bus.openum_out = pkt.openum;
    assign bus.V1_out     = pkt.v1;
    assign bus.V2_out     = pkt.v2;
    assign bus.Q1_out     = pkt.q1;
    assign bus.Q2_out     = pkt.q2;
    assign bus.imm_out    = pkt.imm;
    assign bus.pc_out     = pkt.pc;
    assign bus.rob_id_out = pkt.rob_id;
    assign bus.rename_rd  = pkt.rename_rd;
    assign bus.rename_tag = pkt.rename_tag;

endmodule

// File: tb/tb_dispatcher.sv
// Directed plus randomized bench for dispatcher against a cycle-level reference model.
module tb_dispatcher;
    import dispatcher_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dispatcher_if bus ();

    dispatcher dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: expected registered outputs and the one-cycle flush flag
    bit                  m_flush;
    logic                e_rs, e_lsb, e_rob, e_ren;
    logic [OPENUM_W-1:0] e_op;
    logic [DATA_W-1:0]   e_v1, e_v2, e_imm;
    logic [TAG_W-1:0]    e_q1, e_q2, e_rob_id, e_ren_tag;
    logic [ADDR_W-1:0]   e_pc;
    logic [REG_W-1:0]    e_ren_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W+TAG_W-1:0] resolve(
        input logic [REG_W-1:0] rs, input logic [DATA_W-1:0] v, input logic [TAG_W-1:0] q,
        input logic rdy, input logic [DATA_W-1:0] rval);
        if (rs == 0)                                  return {DATA_W'(0), TAG_W'(0)};
        if (q == 0)                                   return {v, TAG_W'(0)};
`ifdef DSP_CDB_BYPASS_EN
        if (bus.cdb_valid && bus.cdb_tag == q)        return {bus.cdb_result, TAG_W'(0)};
`endif
        if (rdy)                                      return {rval, TAG_W'(0)};
        return {DATA_W'(0), q};
    endfunction

    function automatic logic model_ready();
        logic stall = 1'b0;
        logic full;
`ifndef DSP_CDB_BYPASS_EN
        stall = bus.cdb_valid && ((bus.rf_Q1 != 0 && bus.rf_Q1 == bus.cdb_tag) ||
                                  (bus.rf_Q2 != 0 && bus.rf_Q2 == bus.cdb_tag));
`endif
        full = bus.rob_full || (bus.is_ls_in ? bus.lsb_full : bus.rs_full);
        return !m_flush && !bus.rollback && !full && !stall;
    endfunction

    // One clock: check ready, advance the model, then check every registered output
    task automatic cycle();
        logic er = 1'b0;
        logic [DATA_W+TAG_W-1:0] r1, r2;
        #1;
        if (!rst) begin
            er = model_ready();
            chk("inst_ready", 64'(bus.inst_ready), 64'(er));
        end
        if (rst) begin
            m_flush = 1'b0;
            {e_rs, e_lsb, e_rob, e_ren} = '0;
            e_op = '0; e_v1 = '0; e_v2 = '0; e_q1 = '0; e_q2 = '0; e_imm = '0;
            e_pc = '0; e_rob_id = '0; e_ren_rd = '0; e_ren_tag = '0;
        end else begin
            {e_rs, e_lsb, e_rob, e_ren} = '0;
            e_op = '0;
            if (bus.inst_valid && er) begin
                r1 = resolve(bus.rs1_in, bus.rf_V1, bus.rf_Q1, bus.rob_ready1, bus.rob_val1);
                r2 = resolve(bus.rs2_in, bus.rf_V2, bus.rf_Q2, bus.rob_ready2, bus.rob_val2);
                e_rs = !bus.is_ls_in; e_lsb = bus.is_ls_in; e_rob = 1'b1;
                e_ren = (bus.rd_in != 0);
                e_op = bus.openum_in;
                {e_v1, e_q1} = r1;
                {e_v2, e_q2} = r2;
                e_imm = bus.imm_in; e_pc = bus.pc_in; e_rob_id = bus.rob_free_tag;
                e_ren_rd = bus.rd_in; e_ren_tag = bus.rob_free_tag;
            end
            m_flush = bus.rollback;
        end
        @(posedge clk);
        #1;
        chk("rs_ena",     64'(bus.rs_ena),     64'(e_rs));
        chk("lsb_ena",    64'(bus.lsb_ena),    64'(e_lsb));
        chk("rob_ena",    64'(bus.rob_ena),    64'(e_rob));
        chk("rename_ena", 64'(bus.rename_ena), 64'(e_ren));
        chk("openum_out", 64'(bus.openum_out), 64'(e_op));
        chk("V1_out",     64'(bus.V1_out),     64'(e_v1));
        chk("V2_out",     64'(bus.V2_out),     64'(e_v2));
        chk("Q1_out",     64'(bus.Q1_out),     64'(e_q1));
        chk("Q2_out",     64'(bus.Q2_out),     64'(e_q2));
        chk("imm_out",    64'(bus.imm_out),    64'(e_imm));
        chk("pc_out",     64'(bus.pc_out),     64'(e_pc));
        chk("rob_id_out", 64'(bus.rob_id_out), 64'(e_rob_id));
        chk("rename_rd",  64'(bus.rename_rd),  64'(e_ren_rd));
        chk("rename_tag", 64'(bus.rename_tag), 64'(e_ren_tag));
    endtask

    task automatic idle_inputs();
        bus.inst_valid = 1'b0; bus.openum_in = '0; bus.is_ls_in = 1'b0;
        bus.rd_in = '0; bus.rs1_in = '0; bus.rs2_in = '0; bus.imm_in = '0; bus.pc_in = '0;
        bus.rf_V1 = '0; bus.rf_V2 = '0; bus.rf_Q1 = '0; bus.rf_Q2 = '0;
        bus.rob_free_tag = '0; bus.rob_full = 1'b0; bus.rs_full = 1'b0; bus.lsb_full = 1'b0;
        bus.rob_ready1 = 1'b0; bus.rob_ready2 = 1'b0; bus.rob_val1 = '0; bus.rob_val2 = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_result = '0; bus.rollback = 1'b0;
    endtask

    initial begin
        int pulses;
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_openum_nop", 64'(bus.openum_out), 64'(OP_NOP));
        chk("rst_rob_ena",    64'(bus.rob_ena),    64'd0);
        rst = 1'b0;

        // ADDI x1 <- x0 + 5 with ROB tag 3
        bus.inst_valid = 1'b1; bus.openum_in = OPENUM_W'(OP_ADDI); bus.rd_in = 5'd1;
        bus.rs1_in = 5'd0; bus.rf_V1 = 32'h1234; bus.imm_in = 32'd5; bus.pc_in = 32'h100;
        bus.rob_free_tag = 5'd3;
        cycle();
        chk("addi_rs_ena",  64'(bus.rs_ena),     64'd1);
        chk("addi_V1",      64'(bus.V1_out),     64'd0);
        chk("addi_Q1",      64'(bus.Q1_out),     64'd0);
        chk("addi_imm",     64'(bus.imm_out),    64'd5);
        chk("addi_rob_id",  64'(bus.rob_id_out), 64'd3);
        chk("addi_ren",     64'(bus.rename_ena), 64'd1);
        chk("addi_ren_rd",  64'(bus.rename_rd),  64'd1);
        chk("addi_ren_tag", 64'(bus.rename_tag), 64'd3);
        bus.inst_valid = 1'b0;
        cycle();
        chk("idle_rs_ena", 64'(bus.rs_ena),     64'd0);
        chk("idle_nop",    64'(bus.openum_out), 64'(OP_NOP));
        chk("idle_hold",   64'(bus.imm_out),    64'd5);

        // rs1 waits on tag 4 while the CDB broadcasts tag 4
        bus.inst_valid = 1'b1; bus.openum_in = OPENUM_W'(OP_ADD); bus.rd_in = 5'd2;
        bus.rs1_in = 5'd1; bus.rf_Q1 = 5'd4; bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd4;
        bus.cdb_result = 32'h55; bus.rob_free_tag = 5'd5;
`ifdef DSP_CDB_BYPASS_EN
        cycle();
        chk("byp_V1",     64'(bus.V1_out), 64'h55);
        chk("byp_Q1",     64'(bus.Q1_out), 64'd0);
        chk("byp_rs_ena", 64'(bus.rs_ena), 64'd1);
`else
        #1;
        chk("stall_ready", 64'(bus.inst_ready), 64'd0);
        cycle();
        chk("stall_rs_ena", 64'(bus.rs_ena), 64'd0);
        bus.cdb_valid = 1'b0; bus.rob_ready1 = 1'b1; bus.rob_val1 = 32'h55;
        cycle();
        chk("rob_V1",     64'(bus.V1_out), 64'h55);
        chk("rob_Q1",     64'(bus.Q1_out), 64'd0);
        chk("rob_rs_ena", 64'(bus.rs_ena), 64'd1);
`endif
        bus.cdb_valid = 1'b0; bus.rob_ready1 = 1'b0; bus.rf_Q1 = '0;

        // rs2 waits on tag 7, not ready anywhere
        bus.rs1_in = 5'd0; bus.rs2_in = 5'd3; bus.rf_Q2 = 5'd7; bus.rf_V2 = 32'hBEEF;
        cycle();
        chk("wait_Q2", 64'(bus.Q2_out), 64'd7);
        chk("wait_V2", 64'(bus.V2_out), 64'd0);
        bus.rf_Q2 = '0;

        // RS full for three cycles, then exactly one pulse
        bus.rs_full = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_ready", 64'(bus.inst_ready), 64'd0);
            cycle();
            pulses += int'(bus.rs_ena);
        end
        bus.rs_full = 1'b0;
        cycle();
        pulses += int'(bus.rs_ena);
        bus.inst_valid = 1'b0;
        cycle();
        pulses += int'(bus.rs_ena);
        chk("full_one_pulse", 64'(pulses), 64'd1);

        // Store goes to the LSB even with the RS full
        bus.inst_valid = 1'b1; bus.is_ls_in = 1'b1; bus.openum_in = OPENUM_W'(OP_SW);
        bus.rd_in = 5'd0; bus.rs_full = 1'b1;
        cycle();
        chk("st_lsb_ena", 64'(bus.lsb_ena),    64'd1);
        chk("st_rs_ena",  64'(bus.rs_ena),     64'd0);
        chk("st_ren",     64'(bus.rename_ena), 64'd0);
        bus.rs_full = 1'b0; bus.is_ls_in = 1'b0; bus.openum_in = OPENUM_W'(OP_ADD);

        // Rollback beats accept, then one flush cycle
        bus.rollback = 1'b1;
        cycle();
        chk("rb_rs_ena",  64'(bus.rs_ena),  64'd0);
        chk("rb_rob_ena", 64'(bus.rob_ena), 64'd0);
        bus.rollback = 1'b0;
        #1;
        chk("flush_ready", 64'(bus.inst_ready), 64'd0);
        cycle();
        chk("flush_rs_ena", 64'(bus.rs_ena), 64'd0);
        cycle();
        chk("post_flush_rs_ena", 64'(bus.rs_ena), 64'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst                = ($urandom_range(0, 99) == 0);
            bus.inst_valid     = ($urandom_range(0, 3) != 0);
            bus.openum_in      = OPENUM_W'($urandom_range(0, 6));
            bus.is_ls_in       = 1'($urandom_range(0, 1));
            bus.rd_in          = REG_W'($urandom_range(0, 3));
            bus.rs1_in         = REG_W'($urandom_range(0, 3));
            bus.rs2_in         = REG_W'($urandom_range(0, 3));
            bus.imm_in         = $urandom;
            bus.pc_in          = $urandom;
            bus.rf_V1          = $urandom;
            bus.rf_V2          = $urandom;
            bus.rf_Q1          = TAG_W'($urandom_range(0, 7));
            bus.rf_Q2          = TAG_W'($urandom_range(0, 7));
            bus.rob_free_tag   = TAG_W'($urandom_range(1, 31));
            bus.rob_full       = ($urandom_range(0, 7) == 0);
            bus.rs_full        = ($urandom_range(0, 3) == 0);
            bus.lsb_full       = ($urandom_range(0, 3) == 0);
            bus.rob_ready1     = 1'($urandom_range(0, 1));
            bus.rob_ready2     = 1'($urandom_range(0, 1));
            bus.rob_val1       = $urandom;
            bus.rob_val2       = $urandom;
            bus.cdb_valid      = 1'($urandom_range(0, 1));
            bus.cdb_tag        = TAG_W'($urandom_range(0, 7));
            bus.cdb_result     = $urandom;
            bus.rollback       = !m_flush && ($urandom_range(0, 15) == 0);
            cycle();
        end

        rst = 1'b0;
        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatcher.md
Name: dispatcher

Overview:
- Single registered stage between the instruction queue / decoder and the execution back end (reservation station, load-store buffer, ROB, register file).
- Each cycle it accepts at most one decoded instruction.
- It resolves source operands to values or producer tags, allocates a ROB entry, renames rd in the register file, and issues a one-cycle enable pulse to either the RS or the LSB.
- It stalls on any full structure and drops all state on rollback.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 32, pc width
- OPENUM_W, 6, operation enum width; value 0 = NOP
- TAG_W, 5, ROB tag width; tag 0 = no dependency, valid tags 1..2^TAG_W-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst_valid  in  1  decoded instruction present
- inst_ready  out  1  dispatcher accepts this cycle (combinational)
- openum_in  in  OPENUM_W  decoded op
- is_ls_in  in  1  load/store -> LSB, else RS
- rd_in, rs1_in, rs2_in  in  5 each  register indices
- imm_in  in  DATA_W  immediate
- pc_in  in  ADDR_W  instruction pc
- rf_V1, rf_V2  in  DATA_W  register file values for rs1/rs2
- rf_Q1, rf_Q2  in  TAG_W  register file rename tags
- rob_free_tag  in  TAG_W  next ROB tag
- rob_full, rs_full, lsb_full  in  1  structure full
- rob_ready1, rob_ready2  in  1  ROB entry rf_Qx already has its result
- rob_val1, rob_val2  in  DATA_W  that result
- cdb_valid  in  1  CDB broadcast
- cdb_tag  in  TAG_W  broadcast tag
- cdb_result  in  DATA_W  broadcast value
- rollback  in  1  mispredict flush
- rs_ena, lsb_ena  out  1  insert pulse
- openum_out  out  OPENUM_W
- V1_out, V2_out  out  DATA_W
- Q1_out, Q2_out  out  TAG_W
- imm_out  out  DATA_W
- pc_out  out  ADDR_W
- rob_id_out  out  TAG_W
- rob_ena  out  1  allocate ROB entry
- rename_ena  out  1  register file rename pulse
- rename_rd  out  5
- rename_tag  out  TAG_W

Behaviour:
- Reset: all outputs 0, state RUN; openum_out = NOP, all enables 0.
- States:
  - RUN: normal operation.
  - FLUSH: entered on rollback; lasts exactly one cycle; inst_ready = 0; returns to RUN.
- inst_ready = (state == RUN) & !rollback & !rob_full & (is_ls_in ? !lsb_full : !rs_full) & !bypass_stall.
- Accept = inst_valid & inst_ready.
- On accept, all outputs are registered at the next edge, so latency is 1 cycle:
  - rs_ena = !is_ls_in; lsb_ena = is_ls_in.
  - rob_ena = 1; rob_id_out = rob_free_tag.
- Rename:
  - rename_ena = 1 iff rd_in != 0; rename_rd = rd_in; rename_tag = rob_free_tag.
- Operand x (x = 1, 2) resolution, highest priority first:
  1. rs_x == 0 -> V = 0, Q = 0.
  2. rf_Qx == 0 -> V = rf_Vx, Q = 0.
  3. cdb_valid & cdb_tag == rf_Qx -> V = cdb_result, Q = 0.
  4. rob_readyx -> V = rob_valx, Q = 0.
  5. Otherwise V = 0, Q = rf_Qx.
- imm_out, pc_out and openum_out are passed through unchanged.
- No accept: all enables are 0 next cycle and openum_out = NOP; data outputs hold their previous values.
- Enables are single-cycle pulses; they never stay high for 2 cycles from one instruction.
- rollback has priority over accept in the same cycle: the instruction is dropped, all enables are 0 next cycle, and state goes to FLUSH.
- Reset during FLUSH returns to RUN with all outputs 0.
- A full flag rising in the same cycle blocks acceptance in that cycle.

Optional Feature:
- Macro DSP_CDB_BYPASS_EN.
- Defined: priority step 3 is active; bypass_stall = 0.
- Undefined: step 3 is removed, and bypass_stall = cdb_valid & (rf_Q1 or rf_Q2 nonzero and equal to cdb_tag). The instruction is held one cycle and resolves through the ROB path on the next cycle.

Decomposition:
- Shared package/defines file holds:
  - OPENUM enum including NOP = 0
  - ZERO_TAG
  - DATA/ADDR/TAG widths
  - TRUE/FALSE
- One natural sub-module: operand_resolve, combinational, instantiated twice. Inputs rs, rf_V, rf_Q, cdb_*, rob_ready, rob_val; outputs V, Q.

Test Plan:
- Reset then ADDI x1 ← x0+5 (rob_free_tag = 3) -> next cycle rs_ena = 1, V1 = 0, Q1 = 0, imm_out = 5, rob_id_out = 3, rename_ena = 1 with rd 1, tag 3.
- rf_Q1 = 4, cdb_valid with tag 4 and result 0x55 in the same cycle:
  - bypass built -> V1_out = 0x55, Q1_out = 0.
  - bypass not built -> inst_ready = 0 for 1 cycle, then V1 is taken from rob_val1.
- rf_Q2 = 7, rob_ready2 = 0, no CDB -> Q2_out = 7, V2_out = 0.
- rs_full = 1 with a non-ls instruction held for 3 cycles -> inst_ready = 0 and no enables; rs_full drops -> exactly one rs_ena pulse.
- Store with lsb_full = 0 and rs_full = 1 -> accepted, lsb_ena = 1, rs_ena = 0.
- rollback together with inst_valid -> no enables next cycle, inst_ready = 0 during FLUSH, accepts again the cycle after.
